// File: rtl/boss_pkg.sv
// Shared definitions for the little-boss sprite renderer: sprite geometry,
// the lifecycle state encoding and the transparent colour key.
package boss_pkg;

  localparam int SPRITE_W  = 41;
  localparam int SPRITE_H  = 41;
  localparam int ROM_DEPTH = SPRITE_W * SPRITE_H;
  localparam int ADDR_W    = 19;
  localparam int COLOR_W   = 24;
  localparam int CNT_W     = 6;

  localparam logic [COLOR_W-1:0] TRANSP_KEY = 24'h000000;

  // Encoding is visible to game logic through boss_state, so values are fixed.
  typedef enum logic [1:0] {
    DEAD  = 2'd0,
    ALIVE = 2'd1,
    FLASH = 2'd2,
    DYING = 2'd3
  } boss_state_t;

  // Frame counter increment that sticks at all-ones instead of wrapping, so a
  // misconfigured frame count can never alias back to an early effect phase.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
    return (value == {CNT_W{1'b1}}) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// Combinational sprite hit test and sprite-RAM offset calculation.
// The parent registers the results; the offset is only meaningful when
// o_inBox is high.
module sprite_addr_gen
  import boss_pkg::*;
(
  input  logic [9:0]        i_drawX,
  input  logic [9:0]        i_drawY,
  input  logic [9:0]        i_bossX,
  input  logic [9:0]        i_bossY,
  output logic              o_inBox,
  output logic [ADDR_W-1:0] o_offset
);

  logic [10:0]       w_drawX11;
  logic [10:0]       w_drawY11;
  logic [10:0]       w_bossX11;
  logic [10:0]       w_bossY11;
  logic [10:0]       w_xEnd;
  logic [10:0]       w_yEnd;
  logic              w_inX;
  logic              w_inY;
  logic [9:0]        w_dx;
  logic [9:0]        w_dy;

  // Bounds are compared at 11 bits so a sprite near the right/bottom edge of
  // the 10-bit coordinate space never wraps its far edge back to zero.
  assign w_drawX11 = {1'b0, i_drawX};
  assign w_drawY11 = {1'b0, i_drawY};
  assign w_bossX11 = {1'b0, i_bossX};
  assign w_bossY11 = {1'b0, i_bossY};
  assign w_xEnd    = w_bossX11 + 11'(SPRITE_W);
  assign w_yEnd    = w_bossY11 + 11'(SPRITE_H);

  assign w_inX   = (w_drawX11 >= w_bossX11) && (w_drawX11 < w_xEnd);
  assign w_inY   = (w_drawY11 >= w_bossY11) && (w_drawY11 < w_yEnd);
  assign o_inBox = w_inX && w_inY;

  // Row-major offset into the sprite image; peaks at ROM_DEPTH-1 inside the box.
  assign w_dx     = i_drawX - i_bossX;
  assign w_dy     = i_drawY - i_bossY;
  assign o_offset = ({9'd0, w_dy} * ADDR_W'(SPRITE_W)) + {9'd0, w_dx};

endmodule

// File: rtl/boss_sprite_renderer.sv
// Boss sprite pixel stage: drives the sprite RAM address from the scan
// position, keys out transparent pixels and overlays hit-flash and death-blink
// effects driven by a frame-counted lifecycle FSM. Pixel latency is 3 cycles.
module boss_sprite_renderer
  import boss_pkg::*;
#(
  parameter logic [COLOR_W-1:0] FLASH_COLOR  = 24'hFFFFFF,
  parameter int                 FLASH_FRAMES = 8,
  parameter int                 DIE_FRAMES   = 32
)
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_clk,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic [9:0]         boss_x,
  input  logic [9:0]         boss_y,
  input  logic               spawn,
  input  logic               hit,
  input  logic               kill,
  output logic [ADDR_W-1:0]  read_address,
  input  logic [COLOR_W-1:0] data_Out_boss,
  output logic               boss_on,
  output logic [COLOR_W-1:0] boss_rgb,
  output logic [1:0]         boss_state
);

  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_FRAMES - 1);
  localparam logic [CNT_W-1:0] DIE_LAST   = CNT_W'(DIE_FRAMES - 1);

  logic               r_frameClkQ;
  logic               w_frameTick;

  boss_state_t        r_state;
  boss_state_t        w_stateNext;
  logic [CNT_W-1:0]   r_counter;
  logic [CNT_W-1:0]   w_counterNext;

  logic               w_inBox;
  logic [ADDR_W-1:0]  w_offset;
  logic [ADDR_W-1:0]  r_readAddress;
  logic               r_v1;
  logic               r_v2;

  logic               w_flashActive;
  logic               w_blinkVisible;
  logic               w_pixelOn;
  logic               r_bossOn;
  logic [COLOR_W-1:0] r_bossRgb;

  sprite_addr_gen u_addrGen (
    .i_drawX  (DrawX),
    .i_drawY  (DrawY),
    .i_bossX  (boss_x),
    .i_bossY  (boss_y),
    .o_inBox  (w_inBox),
    .o_offset (w_offset)
  );

  // Delay frame_clk once so its rising edge becomes a single-cycle tick.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_frameClkQ <= 1'b0;
    end else begin
      r_frameClkQ <= frame_clk;
    end
  end

  assign w_frameTick = frame_clk & ~r_frameClkQ;

  // Lifecycle state and effect frame counter registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= DEAD;
      r_counter <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_counter <= w_counterNext;
    end
  end

  // Next-state logic; spawn beats kill beats hit beats frame counting, and any
  // event in a tick cycle suppresses the count for that cycle.
  always_comb begin
    w_stateNext   = r_state;
    w_counterNext = r_counter;
    if (spawn) begin
      w_stateNext   = ALIVE;
      w_counterNext = '0;
    end else begin
      case (r_state)
        DEAD: begin
        end
        ALIVE: begin
          if (kill) begin
            w_stateNext   = DYING;
            w_counterNext = '0;
          end else if (hit) begin
            w_stateNext   = FLASH;
            w_counterNext = '0;
          end
        end
        FLASH: begin
          if (kill) begin
            w_stateNext   = DYING;
            w_counterNext = '0;
          end else if (hit) begin
            w_counterNext = '0;
          end else if (w_frameTick) begin
            if (r_counter >= FLASH_LAST) begin
              w_stateNext   = ALIVE;
              w_counterNext = '0;
            end else begin
              w_counterNext = satInc(r_counter);
            end
          end
        end
        DYING: begin
          if (w_frameTick) begin
            if (r_counter >= DIE_LAST) begin
              w_stateNext   = DEAD;
              w_counterNext = '0;
            end else begin
              w_counterNext = satInc(r_counter);
            end
          end
        end
        default: begin
          w_stateNext   = DEAD;
          w_counterNext = '0;
        end
      endcase
    end
  end

  // Stage 1: latch the RAM address for in-box pixels and qualify with liveness.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_readAddress <= '0;
      r_v1          <= 1'b0;
    end else begin
      if (w_inBox) begin
        r_readAddress <= w_offset;
      end
      r_v1 <= w_inBox && (r_state != DEAD);
    end
  end

  // Stage 2: track validity while the RAM registers its read data.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_v2 <= 1'b0;
    end else begin
      r_v2 <= r_v1;
    end
  end

  // White on even flash frames; hidden on counter phases 4-7 of each 8 while dying.
  assign w_flashActive  = (r_state == FLASH) && !r_counter[0];
  assign w_blinkVisible = (r_state != DYING) || !r_counter[2];
  assign w_pixelOn      = r_v2 && (data_Out_boss != TRANSP_KEY) && w_blinkVisible;

  // Stage 3: key out transparency, apply effects and register the pixel.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_bossOn  <= 1'b0;
      r_bossRgb <= '0;
    end else begin
      r_bossOn <= w_pixelOn;
      if (w_pixelOn) begin
        r_bossRgb <= w_flashActive ? FLASH_COLOR : data_Out_boss;
      end else begin
        r_bossRgb <= '0;
      end
    end
  end

  assign read_address = r_readAddress;
  assign boss_on      = r_bossOn;
  assign boss_rgb     = r_bossRgb;
  assign boss_state   = r_state;

endmodule

// File: tb/tb_boss_sprite_renderer.sv
// Directed bench for boss_sprite_renderer with a behavioural sprite RAM.
module tb_boss_sprite_renderer;

  logic        Clk;
  logic        Reset;
  logic        frame_clk;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [9:0]  boss_x;
  logic [9:0]  boss_y;
  logic        spawn;
  logic        hit;
  logic        kill;
  logic [18:0] read_address;
  logic [23:0] data_Out_boss;
  logic        boss_on;
  logic [23:0] boss_rgb;
  logic [1:0]  boss_state;

  logic [23:0] ram [0:1680];

  int vectors;
  int miscompares;

  boss_sprite_renderer dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_clk     (frame_clk),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .boss_x        (boss_x),
    .boss_y        (boss_y),
    .spawn         (spawn),
    .hit           (hit),
    .kill          (kill),
    .read_address  (read_address),
    .data_Out_boss (data_Out_boss),
    .boss_on       (boss_on),
    .boss_rgb      (boss_rgb),
    .boss_state    (boss_state)
  );

  // Free-running pixel clock.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Synchronous-read sprite RAM: data valid one cycle after the address.
  always @(posedge Clk) begin
    data_Out_boss <= ram[read_address[10:0]];
  end

  // Advance n clock edges and settle just past the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One rising edge on frame_clk, i.e. exactly one frame tick.
  task automatic frameEdge();
    frame_clk = 1'b1;
    tick(1);
    frame_clk = 1'b0;
    tick(1);
  endtask

  task automatic pulse(input logic s, input logic k, input logic h);
    spawn = s;
    kill  = k;
    hit   = h;
    tick(1);
    spawn = 1'b0;
    kill  = 1'b0;
    hit   = 1'b0;
  endtask

  // Present one pixel for a single cycle, then park the scan off-sprite.
  task automatic applyStimulus(input string tag, input logic [9:0] x, input logic [9:0] y,
                               input logic [18:0] expAddr, input logic expOn,
                               input logic [23:0] expRgb);
    DrawX = x;
    DrawY = y;
    tick(1);
    DrawX = 10'd0;
    DrawY = 10'd0;
    checkOutput({tag, ".addr"}, 32'(read_address), 32'(expAddr));
    tick(2);
    checkOutput({tag, ".on"}, 32'(boss_on), 32'(expOn));
    checkOutput({tag, ".rgb"}, 32'(boss_rgb), 32'(expRgb));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int a = 0; a < 1681; a++) begin
      ram[a] = 24'h100000 | 24'(a);
    end
    ram[0] = 24'h12AB34;
    ram[5] = 24'h000000;

    Reset     = 1'b1;
    frame_clk = 1'b0;
    DrawX     = 10'd0;
    DrawY     = 10'd0;
    boss_x    = 10'd100;
    boss_y    = 10'd200;
    spawn     = 1'b0;
    hit       = 1'b0;
    kill      = 1'b0;
    tick(3);
    checkOutput("reset.state", 32'(boss_state), 32'd0);
    checkOutput("reset.on", 32'(boss_on), 32'd0);
    checkOutput("reset.rgb", 32'(boss_rgb), 32'd0);
    checkOutput("reset.addr", 32'(read_address), 32'd0);
    Reset = 1'b0;
    tick(1);

    // Dead boss: address still tracks, nothing drawn, hit/kill ignored.
    applyStimulus("dead.px", 10'd101, 10'd201, 19'd42, 1'b0, 24'h0);
    pulse(1'b0, 1'b1, 1'b1);
    checkOutput("dead.ignore", 32'(boss_state), 32'd0);

    pulse(1'b1, 1'b0, 1'b0);
    checkOutput("spawn.state", 32'(boss_state), 32'd1);

    // Geometry: corners, just outside, transparency.
    applyStimulus("tl", 10'd100, 10'd200, 19'd0, 1'b1, 24'h12AB34);
    applyStimulus("br", 10'd140, 10'd240, 19'd1680, 1'b1, 24'h100690);
    applyStimulus("rightOut", 10'd141, 10'd240, 19'd1680, 1'b0, 24'h0);
    applyStimulus("bottomOut", 10'd100, 10'd241, 19'd1680, 1'b0, 24'h0);
    applyStimulus("leftOut", 10'd99, 10'd200, 19'd1680, 1'b0, 24'h0);
    applyStimulus("transp", 10'd105, 10'd200, 19'd5, 1'b0, 24'h0);
    applyStimulus("mid", 10'd101, 10'd201, 19'd42, 1'b1, 24'h10002A);

    // Hit flash: white on even counts, 8 ticks, then back to alive.
    pulse(1'b0, 1'b0, 1'b1);
    checkOutput("flash.state0", 32'(boss_state), 32'd2);
    applyStimulus("flash.c0", 10'd101, 10'd201, 19'd42, 1'b1, 24'hFFFFFF);
    for (int f = 1; f < 8; f++) begin
      frameEdge();
      checkOutput($sformatf("flash.state%0d", f), 32'(boss_state), 32'd2);
      applyStimulus($sformatf("flash.c%0d", f), 10'd101, 10'd201, 19'd42, 1'b1,
                    (f % 2 == 0) ? 24'hFFFFFF : 24'h10002A);
    end
    frameEdge();
    checkOutput("flash.done", 32'(boss_state), 32'd1);
    applyStimulus("flash.after", 10'd101, 10'd201, 19'd42, 1'b1, 24'h10002A);

    // Re-hit at count 5 restarts the flash window.
    pulse(1'b0, 1'b0, 1'b1);
    repeat (5) frameEdge();
    applyStimulus("rehit.c5", 10'd101, 10'd201, 19'd42, 1'b1, 24'h10002A);
    pulse(1'b0, 1'b0, 1'b1);
    applyStimulus("rehit.c0", 10'd101, 10'd201, 19'd42, 1'b1, 24'hFFFFFF);
    repeat (7) frameEdge();
    checkOutput("rehit.state7", 32'(boss_state), 32'd2);
    frameEdge();
    checkOutput("rehit.done", 32'(boss_state), 32'd1);

    // Event plus frame tick in one cycle: the hit wins, count stays at 0.
    pulse(1'b0, 1'b0, 1'b1);
    frameEdge();
    applyStimulus("tickhit.c1", 10'd101, 10'd201, 19'd42, 1'b1, 24'h10002A);
    frame_clk = 1'b1;
    pulse(1'b0, 1'b0, 1'b1);
    frame_clk = 1'b0;
    tick(1);
    applyStimulus("tickhit.c0", 10'd101, 10'd201, 19'd42, 1'b1, 24'hFFFFFF);

    // spawn beats kill beats hit.
    pulse(1'b1, 1'b1, 1'b1);
    checkOutput("prio.state", 32'(boss_state), 32'd1);
    applyStimulus("prio.px", 10'd101, 10'd201, 19'd42, 1'b1, 24'h10002A);

    // Death: blink 4 on / 4 off, dead after 32 ticks.
    pulse(1'b0, 1'b1, 1'b0);
    checkOutput("die.state0", 32'(boss_state), 32'd3);
    applyStimulus("die.c0", 10'd101, 10'd201, 19'd42, 1'b1, 24'h10002A);
    for (int f = 1; f < 32; f++) begin
      frameEdge();
      if (f < 8) begin
        applyStimulus($sformatf("die.c%0d", f), 10'd101, 10'd201, 19'd42, (f < 4),
                      (f < 4) ? 24'h10002A : 24'h0);
      end
    end
    checkOutput("die.state31", 32'(boss_state), 32'd3);
    frameEdge();
    checkOutput("die.dead", 32'(boss_state), 32'd0);
    applyStimulus("die.after", 10'd101, 10'd201, 19'd42, 1'b0, 24'h0);

    // Reset with in-box pixels in flight while dying.
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    DrawX = 10'd101;
    DrawY = 10'd201;
    tick(2);
    Reset = 1'b1;
    tick(1);
    checkOutput("rst.state", 32'(boss_state), 32'd0);
    checkOutput("rst.on", 32'(boss_on), 32'd0);
    checkOutput("rst.addr", 32'(read_address), 32'd0);
    Reset = 1'b0;
    DrawX = 10'd0;
    DrawY = 10'd0;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      checkOutput($sformatf("rst.stale%0d", k), 32'(boss_on), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
